// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 2-flop input synchroniser,
// mid-bit sampling, start-bit glitch rejection, optional parity and 1/2 stop bits.
// Ports: clk, rst (async, active-high), rx (serial in, idles high),
//        data_out (last word), rx_valid (1-cycle strobe), parity_err,
//        frame_err (held with data_out), busy (frame in progress).
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_BITS + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          PAR_ON    = (PARITY_EN != 0);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_BRK   = 3'd5;

    logic [1:0]           sync_q, sync_d;
    logic [2:0]           state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [CW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 busy_q, busy_d;

    logic rx_s;
    logic baud_end;
    logic par_exp;
    logic ferr_now;

    assign rx_s     = sync_q[1];
    assign baud_end = (baud_q == BAUD_LAST);
    assign par_exp  = (^shift_q) ^ PAR_ODD;
    // stop sample folded into the running flag so the last sample counts
    assign ferr_now = ferr_q | ~rx_s;

    always_comb begin
        sync_d     = {sync_q[0], rx};
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    baud_d  = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            S_START: begin
                if (baud_q == BAUD_HALF) begin
                    // high at mid start bit: a glitch, not a frame
                    if (!rx_s) begin
                        state_d = S_DATA;
                        baud_d  = '0;
                        bit_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    // shifting in at the top leaves bit 0 at the LSB
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_LAST) begin
                        state_d = PAR_ON ? S_PAR : S_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_PAR: begin
                if (baud_end) begin
                    baud_d  = '0;
                    perr_d  = (rx_s != par_exp);
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    ferr_d = ferr_now;
                    if (stop_q == STOP_LAST) begin
                        data_d     = shift_q;
                        perr_out_d = PAR_ON & perr_q;
                        ferr_out_d = ferr_now;
                        valid_d    = 1'b1;
                        state_d    = ferr_now ? S_BRK : S_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_BRK: begin
                // wait out a held-low line before hunting for a start bit
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 2'b11;
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            busy_q     <= busy_d;
        end
    end

    assign data_out   = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign busy       = busy_q;

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver; next generation of the team's fixed 8-bit receiver.
- Adds:
  - baud-rate divisor
  - configurable data width
  - optional parity
  - 1 or 2 stop bits
  - input synchroniser
  - mid-bit sampling
  - glitch rejection
  - parity and framing error flags
- Sits between the serial pin and the byte consumer.
- Delivers one word per frame with a single-cycle valid strobe.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per bit period; must be >= 4.
- DATA_BITS, 8: data bits per frame, 5 to 9, LSB first.
- PARITY_EN, 0: 1 = a parity bit follows the data bits.
- PARITY_ODD, 0: with PARITY_EN=1, 0 = even parity, 1 = odd parity.
- STOP_BITS, 1: 1 or 2 stop bits.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- data_out  output  DATA_BITS  last received word; held until the next frame completes.
- rx_valid  output  1  one-cycle pulse when data_out and the error flags update.
- parity_err  output  1  parity mismatch on the last frame; valid with rx_valid, held after.
- frame_err  output  1  a stop bit sampled low on the last frame; held like parity_err.
- busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset (asynchronous, active-high): state IDLE, counters 0, synchroniser flops = 1, all outputs 0.
- Synchroniser and counters:
  - rx passes through 2 flops; rx_s is the second flop. All decisions use rx_s.
  - baud_cnt counts 0..CLKS_PER_BIT-1. bit_cnt counts data bits; width is clog2(DATA_BITS+1).
- IDLE:
  - rx_s==0 -> START, baud_cnt=0, busy=1.
- START:
  - At baud_cnt==CLKS_PER_BIT/2-1 (integer division), sample rx_s.
  - Sample 0 -> DATA, baud_cnt=0, bit_cnt=0.
  - Sample 1 -> glitch: return to IDLE, busy=0, no rx_valid.
- DATA:
  - At baud_cnt==CLKS_PER_BIT-1, sample rx_s into shift register bit bit_cnt (LSB first) and clear baud_cnt.
  - After sampling bit DATA_BITS-1 -> PARITY if PARITY_EN, else STOP.
- PARITY:
  - Sample at baud_cnt==CLKS_PER_BIT-1.
  - Expected value = XOR of the data bits, inverted if PARITY_ODD.
  - Mismatch sets an internal perr flag.
- STOP:
  - Sample STOP_BITS times, each at baud_cnt==CLKS_PER_BIT-1.
  - Any 0 sample sets an internal ferr flag.
  - After the last stop sample, on the next clk edge:
    - load data_out from the shift register;
    - load parity_err from perr, forced to 0 if PARITY_EN=0;
    - load frame_err from ferr;
    - pulse rx_valid for exactly 1 cycle.
  - Next state: IDLE if ferr==0, else BREAK.
- BREAK:
  - Stay, with busy=1, until rx_s==1, then IDLE.
  - Prevents a held-low line or break from being taken as a new start bit.
- Latency: rx_valid rises 1 clk after the mid-point of the last stop bit. End to end from the rx pin that is about 2 extra clks for synchronisation plus 1.
- Back-to-back frames: a start bit arriving right after the last stop-bit sample is detected in IDLE with no lost bits. data_out stays stable until the next rx_valid.
- Frame-error data: a word with frame_err=1 is still delivered on data_out; the consumer decides whether to discard it.
- Reset mid-frame: immediate abort, all outputs 0, no rx_valid.
- Prohibited latch behaviour: all outputs are registers; no combinational path from rx to any output.

Test Plan:
- Defaults (16 clk/bit, 8N1), send 0xA5 LSB first with a correct stop bit -> exactly one rx_valid pulse; data_out=0xA5; parity_err=0; frame_err=0; busy low after.
- 0x3C then 0xC3 back-to-back with no idle gap -> two rx_valid pulses 160 clks apart; data_out 0x3C, then 0xC3.
- rx low for 5 clks, then high -> no rx_valid; busy returns to 0 within CLKS_PER_BIT/2+3 clks.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 -> rx_valid, data_out=0x07, parity_err=1. Resend with parity bit 1 -> parity_err=0.
- Send 0x55 with stop bit 0, then hold rx low 40 bit-times -> one rx_valid with frame_err=1, data_out=0x55. busy stays 1 while low; no further rx_valid until rx returns high and a new frame is sent.
- STOP_BITS=2, DATA_BITS=7: send 0x5A with the second stop bit low -> frame_err=1. Separately, assert rst at data bit 3 -> outputs 0 immediately; a following clean frame 0x11 is received correctly.
